// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two requesters
// Ports: req_* valid/ready request side (slice i = requester i), rsp_* per-requester
// registered response buffers, alu_* drive to / result from the shared combinational ALU.
module alu_share_arbiter #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*XLEN-1:0]   req_op1,
  input  logic [2*XLEN-1:0]   req_op2,
  input  logic [2*CTRL_W-1:0] req_ctrl,
  input  logic [1:0]          req_sub,
  input  logic [1:0]          req_sign,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [2*XLEN-1:0]   rsp_result,
  output logic [1:0]          rsp_jc,
  output logic [XLEN-1:0]     alu_op1,
  output logic [XLEN-1:0]     alu_op2,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic                alu_sub,
  output logic                alu_sign,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_jc
);
  logic       ptr;
  logic [1:0] elig;
  logic [1:0] grant;
  // a full buffer being drained this cycle can take a new result at the same edge
  assign elig  = req_valid & (~rsp_valid | rsp_ready);
  // on a tie the requester that did not win last time goes next
  assign grant = (elig == 2'b11) ? (ptr ? 2'b01 : 2'b10) : elig;
  assign req_ready = grant;
  always_comb begin
    alu_op1  = grant[1] ? req_op1[XLEN +: XLEN]     : grant[0] ? req_op1[0 +: XLEN]     : '0;
    alu_op2  = grant[1] ? req_op2[XLEN +: XLEN]     : grant[0] ? req_op2[0 +: XLEN]     : '0;
    alu_ctrl = grant[1] ? req_ctrl[CTRL_W +: CTRL_W] : grant[0] ? req_ctrl[0 +: CTRL_W] : '0;
    alu_sub  = grant[1] ? req_sub[1]  : grant[0] & req_sub[0];
    alu_sign = grant[1] ? req_sign[1] : grant[0] & req_sign[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b1;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_jc     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_result[i*XLEN +: XLEN] <= alu_result;
          rsp_jc[i]                  <= alu_jc;
          rsp_valid[i]               <= 1'b1;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
      if (|grant) ptr <= grant[1];
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed table-driven check of alu_share_arbiter with a stub ALU
module tb_alu_share_arbiter;
  localparam logic [3:0] ADD = 4'h0, ORR = 4'h1, BLT = 4'h8;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, req_sub = '0, req_sign = '0;
  logic [63:0] req_op1 = '0, req_op2 = '0;
  logic [7:0]  req_ctrl = '0;
  logic [1:0]  rsp_valid, rsp_ready = '0, rsp_jc;
  logic [63:0] rsp_result;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_sub, alu_sign, alu_jc;
  int          total = 0, passed = 0;
  typedef struct {
    logic [1:0]  rv, rr;
    logic [31:0] a0, b0;
    logic [3:0]  c0;
    logic [31:0] a1, b1;
    logic [3:0]  c1;
    logic [1:0]  sub, sign, e_ready;
    logic [31:0] e_aop1;
    logic [1:0]  e_rv;
    logic [31:0] e_r0, e_r1;
    logic [1:0]  e_jc;
  } vec_t;
  vec_t v[15];
  alu_share_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl), .req_sub(req_sub),
    .req_sign(req_sign), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_jc(rsp_jc), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_ctrl(alu_ctrl), .alu_sub(alu_sub), .alu_sign(alu_sign),
    .alu_result(alu_result), .alu_jc(alu_jc)
  );
  always #5 clk = ~clk;
  always_comb begin
    alu_result = '0;
    alu_jc     = 1'b0;
    if (alu_ctrl == ADD) alu_result = alu_sub ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
    if (alu_ctrl == ORR) alu_result = alu_op1 | alu_op2;
    if (alu_ctrl == BLT) alu_jc = alu_sign ? ($signed(alu_op1) < $signed(alu_op2)) : (alu_op1 < alu_op2);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic drive(input vec_t x);
    req_valid = x.rv;
    rsp_ready = x.rr;
    req_op1   = {x.a1, x.a0};
    req_op2   = {x.b1, x.b0};
    req_ctrl  = {x.c1, x.c0};
    req_sub   = x.sub;
    req_sign  = x.sign;
  endtask
  initial begin
    v[0]  = '{2'b00, 2'b00, 0, 0, ADD, 0, 0, ADD, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 2'b00};
    v[1]  = '{2'b01, 2'b00, 5, 3, ADD, 0, 0, ADD, 2'b01, 2'b00, 2'b01, 5, 2'b01, 2, 0, 2'b00};
    v[2]  = '{2'b00, 2'b00, 5, 3, ADD, 0, 0, ADD, 2'b01, 2'b00, 2'b00, 0, 2'b01, 2, 0, 2'b00};
    v[3]  = '{2'b01, 2'b01, 10, 20, ADD, 0, 0, ADD, 2'b00, 2'b00, 2'b01, 10, 2'b01, 30, 0, 2'b00};
    v[4]  = '{2'b00, 2'b01, 10, 20, ADD, 0, 0, ADD, 2'b00, 2'b00, 2'b00, 0, 2'b00, 30, 0, 2'b00};
    v[5]  = '{2'b10, 2'b00, 0, 0, ADD, 100, 15, ORR, 2'b00, 2'b00, 2'b10, 100, 2'b10, 30, 111, 2'b00};
    v[6]  = '{2'b11, 2'b11, 1, 1, ADD, 7, 1, ADD, 2'b00, 2'b00, 2'b01, 1, 2'b01, 2, 111, 2'b00};
    v[7]  = '{2'b11, 2'b11, 1, 1, ADD, 7, 1, ADD, 2'b00, 2'b00, 2'b10, 7, 2'b10, 2, 8, 2'b00};
    v[8]  = '{2'b11, 2'b11, 1, 1, ADD, 7, 1, ADD, 2'b00, 2'b00, 2'b01, 1, 2'b01, 2, 8, 2'b00};
    v[9]  = '{2'b11, 2'b11, 1, 1, ADD, 7, 1, ADD, 2'b00, 2'b00, 2'b10, 7, 2'b10, 2, 8, 2'b00};
    v[10] = '{2'b00, 2'b10, 1, 1, ADD, 7, 1, ADD, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2, 8, 2'b00};
    v[11] = '{2'b10, 2'b00, 0, 0, ADD, 32'hFFFFFFFF, 1, BLT, 2'b00, 2'b10, 2'b10, 32'hFFFFFFFF, 2'b10, 2, 0, 2'b10};
    v[12] = '{2'b10, 2'b00, 0, 0, ADD, 32'hFFFFFFFF, 1, BLT, 2'b00, 2'b10, 2'b00, 0, 2'b10, 2, 0, 2'b10};
    v[13] = '{2'b10, 2'b10, 0, 0, ADD, 32'hFFFFFFFF, 1, BLT, 2'b00, 2'b10, 2'b10, 32'hFFFFFFFF, 2'b10, 2, 0, 2'b10};
    v[14] = '{2'b10, 2'b10, 0, 0, ADD, 32'hFFFFFFFF, 1, BLT, 2'b00, 2'b00, 2'b10, 32'hFFFFFFFF, 2'b10, 2, 0, 2'b00};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("reset rsp_result", rsp_result, 64'd0);
    chk("reset rsp_jc", {62'd0, rsp_jc}, 64'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(v[i]);
      #1;
      chk($sformatf("v%0d req_ready", i), {62'd0, req_ready}, {62'd0, v[i].e_ready});
      chk($sformatf("v%0d alu_op1", i), {32'd0, alu_op1}, {32'd0, v[i].e_aop1});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), {62'd0, rsp_valid}, {62'd0, v[i].e_rv});
      chk($sformatf("v%0d rsp_result0", i), {32'd0, rsp_result[31:0]}, {32'd0, v[i].e_r0});
      chk($sformatf("v%0d rsp_result1", i), {32'd0, rsp_result[63:32]}, {32'd0, v[i].e_r1});
      chk($sformatf("v%0d rsp_jc", i), {62'd0, rsp_jc}, {62'd0, v[i].e_jc});
    end
    @(negedge clk);
    req_valid = 2'b10; rsp_ready = 2'b00;
    req_op1 = {32'h11, 32'h22}; req_op2 = {32'h33, 32'h44}; req_ctrl = 8'h55;
    req_sub = 2'b11; req_sign = 2'b11;
    #1;
    chk("idle req_ready", {62'd0, req_ready}, 64'd0);
    chk("idle alu bus", {alu_op1, alu_op2[29:0], alu_ctrl[1:0]}, 64'd0);
    chk("idle alu flags", {62'd0, alu_sub, alu_sign}, 64'd0);
    chk("idle alu op2 ctrl", {28'd0, alu_op2, alu_ctrl}, 64'd0);
    @(posedge clk);
    #1;
    chk("idle rsp_valid held", {62'd0, rsp_valid}, 64'd2);
    chk("idle rsp_result held", rsp_result, {32'd0, 32'd2});
    @(negedge clk);
    req_valid = 2'b11; rsp_ready = 2'b00;
    req_op1 = {32'hFFFFFFFF, 32'd5}; req_op2 = {32'd1, 32'd3}; req_ctrl = {BLT, ADD};
    req_sub = 2'b01; req_sign = 2'b10;
    #1 chk("fill ready", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 chk("fill rsp_valid", {62'd0, rsp_valid}, 64'd3);
    @(negedge clk);
    rst = 1'b1; rsp_ready = 2'b11;
    @(posedge clk);
    #1;
    chk("mid reset rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("mid reset rsp_result", rsp_result, 64'd0);
    chk("mid reset rsp_jc", {62'd0, rsp_jc}, 64'd0);
    @(negedge clk);
    rst = 1'b0; rsp_ready = 2'b00;
    #1 chk("post reset tie", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("post reset rsp_valid", {62'd0, rsp_valid}, 64'd1);
    chk("post reset result0", {32'd0, rsp_result[31:0]}, 64'd2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
